hazard_scoreboard: RTL
======================

// Module: hazard_scoreboard
// PURPOSE
//  Producer-side counterpart of the EX/MEM and MEM/WB forwarding unit. The forwarding unit resolves
//  hazards by picking a bypass path; this block decides when a bypass cannot supply a value in time.
//  It sits in the ID stage. For every destination register it tracks the cycles left until the
//  result reaches a forwarding point. It raises stall on a load-use, long-op or WAW hazard.
//  While stalled, PC and IF/ID hold and ID/EX is loaded with a bubble.
// PARAMETERS
//  NUM_REGS  32  architectural registers; r0 is never tracked
//  REG_W     5   register index width
//  LOAD_LAT  1   countdown loaded on issue of a load (MEM-stage result)
//  LONG_LAT  4   countdown loaded on issue of a long op (multi-cycle mul/div)
//  CNT_W     3   countdown width; must hold max(LOAD_LAT, LONG_LAT)
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      asynchronous, active-high; clears all state
//  id_valid     in   1      ID holds a real (non-bubble) instruction
//  id_rs        in   REG_W  source A index
//  id_rt        in   REG_W  source B index
//  id_uses_rs   in   1      instruction reads rs
//  id_uses_rt   in   1      instruction reads rt
//  id_reg_write in   1      instruction writes id_rd
//  id_rd        in   REG_W  destination index
//  id_op_class  in   2      00 ALU, 01 LOAD, 10 LONG, 11 reserved (treated as ALU)
//  flush        in   1      ID instruction is squashed this cycle (taken branch/jump)
//  stall        out  1      hold PC/IF-ID and insert bubble into ID/EX; combinational
//  pending      out  NUM_REGS  bit i = cnt[i] != 0; registered view of the scoreboard
//  stall_cycles out  32     count of cycles with stall=1; wraps at 2^32
// BEHAVIOUR
//  Reset: all cnt[i]=0, pending=0, stall_cycles=0. stall is 0 because every cnt is 0.
//  lat(op): ALU=0, LOAD=LOAD_LAT, LONG=LONG_LAT. An ALU result forwards from EX/MEM with no stall.
//  raw_a = id_uses_rs & (id_rs!=0) & (cnt[id_rs]!=0). raw_b is the same with rt.
//  waw   = id_reg_write & (id_rd!=0) & (cnt[id_rd] > lat(id_op_class)).
//  stall = id_valid & ~flush & (raw_a | raw_b | waw). This path is combinational and has no
//  registered latency.
//  issue = id_valid & ~flush & ~stall & id_reg_write & (id_rd!=0).
//  Per cycle, for each i != 0:
//   - if issue and i==id_rd, cnt[i] <= lat(id_op_class). Issue wins over the decrement.
//   - else if cnt[i]!=0, cnt[i] <= cnt[i]-1.
//   - Decrement continues during stall: the producer keeps advancing while ID is frozen.
//  cnt[0] is held at 0. Writes to r0 never set state, and r0 sources never stall.
//  An issue with lat 0 writes 0. This clears a stale nonzero count only when it is <= 0, i.e.
//  never, because waw would stall first.
//  flush=1 forces stall=0 and suppresses issue. The squashed instruction leaves no state.
//  Counts of older in-flight ops keep decrementing.
//  Simultaneous rs==rt: one hazard, one stall; no double count.
//  Load-use timing: a load issues at cycle t and a dependent instruction is in ID at t+1.
//   stall=1 at t+1 and stall=0 at t+2, so exactly one bubble is inserted.
//  stall_cycles increments on every clock edge where stall=1 and saturation is not applied.
//  Reset asserted mid-stall drops stall in the same cycle (async). Any in-flight countdown is
//  lost; the pipeline flushes on reset anyway.
// STRUCTURE
//  Shared package: op-class codes (OP_ALU/OP_LOAD/OP_LONG) and the default LOAD_LAT/LONG_LAT,
//  which are also used by the control unit.
//  Sub-module scoreboard_entry (one CNT_W down-counter with load/decrement/async clear) is
//  instantiated NUM_REGS-1 times. The top level holds the three lookup muxes, the compare
//  logic, issue decode and the perf counter.
// TESTING
//  1. reset high, then low, random ID traffic with all cnt=0 and ALU-only ops
//     -> stall never 1, pending=0.
//  2. LOAD r5 issues at t; at t+1, ADD r6,r5,r2 (uses_rs)
//     -> stall=1 at t+1, 0 at t+2; pending[5]=1 for one cycle; stall_cycles=1.
//  3. LONG r7 (LONG_LAT=4) at t; dependent on rt=r7 at t+1
//     -> stall=1 for t+1..t+4, released at t+5; stall_cycles=4.
//  4. LONG r8 at t; at t+1, ALU writing r8 with no sources (WAW)
//     -> stall until cnt[8]=0, then issue; pending[8] ends 0.
//  5. LOAD r0, then a user of r0 -> no stall, pending=0. Separately, LOAD r3 followed by a
//     user of r3 with flush=1 that cycle -> stall=0 and no state change.
//  6. LONG r9 issued; reset pulsed asynchronously mid-count with a dependent in ID
//     -> stall drops immediately, pending=0, stall_cycles=0.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: op-class codes and default result latencies shared with the control unit
package hazard_scoreboard_pkg;
    typedef enum logic [1:0] {
        OP_ALU  = 2'b00,
        OP_LOAD = 2'b01,
        OP_LONG = 2'b10,
        OP_RSVD = 2'b11
    } op_class_t;
    localparam int LOAD_LAT_DEF = 1;
    localparam int LONG_LAT_DEF = 4;
endpackage

// File: rtl/hazard_scoreboard_entry.sv
// scoreboard_entry: per-register countdown to the cycle its result reaches a forwarding point
module scoreboard_entry #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk or posedge reset)
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage stall decision for load-use, long-op and WAW hazards
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = LOAD_LAT_DEF,
    parameter int LONG_LAT = LONG_LAT_DEF,
    parameter int CNT_W    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [REG_W-1:0]    id_rs,
    input  logic [REG_W-1:0]    id_rt,
    input  logic                id_uses_rs,
    input  logic                id_uses_rt,
    input  logic                id_reg_write,
    input  logic [REG_W-1:0]    id_rd,
    input  logic [1:0]          id_op_class,
    input  logic                flush,
    output logic                stall,
    output logic [NUM_REGS-1:0] pending,
    output logic [31:0]         stall_cycles
);
    logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lat;
    logic raw_a, raw_b, waw, issue;
    assign lat = id_op_class == OP_LOAD ? CNT_W'(LOAD_LAT) :
                 id_op_class == OP_LONG ? CNT_W'(LONG_LAT) : '0;
    assign raw_a = id_uses_rs && id_rs != '0 && cnt[id_rs] != '0;
    assign raw_b = id_uses_rt && id_rt != '0 && cnt[id_rt] != '0;
    // a younger writer may only overtake when its result lands no earlier than the older one
    assign waw   = id_reg_write && id_rd != '0 && cnt[id_rd] > lat;
    assign stall = id_valid && !flush && (raw_a || raw_b || waw);
    assign issue = id_valid && !flush && !stall && id_reg_write && id_rd != '0;
    assign cnt[0] = '0;
    genvar i;
    generate
        for (i = 1; i < NUM_REGS; i++) begin : g_ent
            scoreboard_entry #(.CNT_W(CNT_W)) u_ent (
                .clk      (clk),
                .reset    (reset),
                .load     (issue && id_rd == REG_W'(i)),
                .load_val (lat),
                .cnt      (cnt[i])
            );
        end
    endgenerate
    always_comb begin
        pending = '0;
        for (int j = 1; j < NUM_REGS; j++)
            pending[j] = cnt[j] != '0;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset)
            stall_cycles <= '0;
        else if (stall)
            stall_cycles <= stall_cycles + 32'd1;
endmodule
